loop_nest_scheduler: RTL

- Three-level nested-loop sequencer (outer c, middle y, inner x) for the memory controller.
- Emits one (c, y, x) index tuple per iteration over a valid/ready handshake to the address generator.
- Each level uses wrap-at-max/stride counting: advance by stride while below max, else wrap to 0.
- Configuration is latched on start; a single-cycle done pulse marks completion.

---
 rtl/loop_nest_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/loop_nest_scheduler.sv
// Three-level nested-loop index sequencer (outer c, middle y, inner x).
// Each level counts 0, s, 2s, ... and ends on the first value >= max, or on
// a value whose next step would overflow DATA_WIDTH. Tuples are presented
// over a valid/ready handshake. A one-cycle done pulse follows the last
// accepted tuple.
module loop_nest_scheduler #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] cfg_max_x,
    input  logic [DATA_WIDTH-1:0] cfg_max_y,
    input  logic [DATA_WIDTH-1:0] cfg_max_c,
    input  logic [DATA_WIDTH-1:0] cfg_stride_x,
    input  logic [DATA_WIDTH-1:0] cfg_stride_y,
    input  logic [DATA_WIDTH-1:0] cfg_stride_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_c,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched configuration (strides already forced non-zero)
    logic [DATA_WIDTH-1:0] max_x_q, max_y_q, max_c_q;
    logic [DATA_WIDTH-1:0] max_x_d, max_y_d, max_c_d;
    logic [DATA_WIDTH-1:0] stride_x_q, stride_y_q, stride_c_q;
    logic [DATA_WIDTH-1:0] stride_x_d, stride_y_d, stride_c_d;

    // Current index tuple
    logic [DATA_WIDTH-1:0] x_q, y_q, c_q;
    logic [DATA_WIDTH-1:0] x_d, y_d, c_d;

    // Next-step sums carry one extra bit to expose overflow
    logic [DATA_WIDTH:0] sum_x, sum_y, sum_c;
    logic                end_x, end_y, end_c;
    logic                valid_int;
    logic                fire;

    // A zero stride would never terminate, so it counts by one instead.
    function automatic logic [DATA_WIDTH-1:0] fix_stride(input logic [DATA_WIDTH-1:0] s);
        return (s == '0) ? DATA_WIDTH'(1) : s;
    endfunction

    // Per-level end-of-range detection
    always_comb begin
        sum_x = {1'b0, x_q} + {1'b0, stride_x_q};
        sum_y = {1'b0, y_q} + {1'b0, stride_y_q};
        sum_c = {1'b0, c_q} + {1'b0, stride_c_q};
        end_x = (x_q >= max_x_q) || sum_x[DATA_WIDTH];
        end_y = (y_q >= max_y_q) || sum_y[DATA_WIDTH];
        end_c = (c_q >= max_c_q) || sum_c[DATA_WIDTH];
    end

    assign valid_int = (state_q == RUN);
    assign fire      = valid_int && out_ready;

    // Next-state, configuration latch and index advance
    always_comb begin
        state_d    = state_q;
        max_x_d    = max_x_q;
        max_y_d    = max_y_q;
        max_c_d    = max_c_q;
        stride_x_d = stride_x_q;
        stride_y_d = stride_y_q;
        stride_c_d = stride_c_q;
        x_d        = x_q;
        y_d        = y_q;
        c_d        = c_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    max_x_d    = cfg_max_x;
                    max_y_d    = cfg_max_y;
                    max_c_d    = cfg_max_c;
                    stride_x_d = fix_stride(cfg_stride_x);
                    stride_y_d = fix_stride(cfg_stride_y);
                    stride_c_d = fix_stride(cfg_stride_c);
                    x_d        = '0;
                    y_d        = '0;
                    c_d        = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (fire) begin
                    if (!end_x) begin
                        x_d = sum_x[DATA_WIDTH-1:0];
                    end else begin
                        x_d = '0;
                        if (!end_y) begin
                            y_d = sum_y[DATA_WIDTH-1:0];
                        end else begin
                            y_d = '0;
                            if (!end_c) begin
                                c_d = sum_c[DATA_WIDTH-1:0];
                            end else begin
                                c_d     = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            DONE: begin
                x_d     = '0;
                y_d     = '0;
                c_d     = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort overrides start and any handshake in the same cycle
        if (abort) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            c_d     = '0;
        end
    end

    // State, configuration and index registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            max_x_q    <= '0;
            max_y_q    <= '0;
            max_c_q    <= '0;
            stride_x_q <= '0;
            stride_y_q <= '0;
            stride_c_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            c_q        <= '0;
        end else begin
            state_q    <= state_d;
            max_x_q    <= max_x_d;
            max_y_q    <= max_y_d;
            max_c_q    <= max_c_d;
            stride_x_q <= stride_x_d;
            stride_y_q <= stride_y_d;
            stride_c_q <= stride_c_d;
            x_q        <= x_d;
            y_q        <= y_d;
            c_q        <= c_d;
        end
    end

    // Output decode
    always_comb begin
        out_valid = valid_int;
        out_x     = x_q;
        out_y     = y_q;
        out_c     = c_q;
        out_last  = valid_int && end_x && end_y && end_c;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

endmodule
